freq_meter_ctrl: RTL
====================

# freq_meter_ctrl

Measurement sequencer for the BCD frequency meter. It owns the 4-digit decimal counter's `enable` and `reset` inputs and runs the measurement cycle: clear the counter, open a precisely timed gate, close it, let the counter settle, then capture its BCD value. The controller sits between the system clock domain and the counter, whose `count[15:0]` output feeds `count_in`. Captured results drive the display and host logic.

## Interface
Parameters:
- `GATE0`, default 1_000_000: gate length in clk cycles for range 0 (1 s at 1 MHz).
- `GATE1`, default 100_000: gate length for range 1 (100 ms).
- `GATE2`, default 10_000: gate length for range 2 (10 ms).
- `GATE3`, default 1_000: gate length for range 3 (1 ms).
- `CLR_CYCLES`, default 2: counter clear pulse length, ≥1.
- `SETTLE_CYCLES`, default 2: wait after gate close before capture, ≥1.
- `HOLD_CYCLES`, default 500_000: result display hold before the next cycle, ≥1.
- `TW`, default 24: timer width; every cycle parameter must be < 2^TW.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  single-shot request; a one-cycle pulse is sufficient.
- `continuous`  in  1  repeat measurements while high.
- `range`  in  2  gate select, 0..3 → GATE0..GATE3.
- `count_in`  in  16  counter BCD value ([3:0] units … [15:12] thousands).
- `cnt_enable`  out  1  to counter `enable`.
- `cnt_reset`  out  1  to counter `reset`, active-low clear.
- `result`  out  16  last captured BCD count.
- `result_range`  out  2  range used for `result`.
- `result_valid`  out  1  one-cycle pulse when `result` updates.
- `busy`  out  1  high in every state except IDLE.

## Operation
- States: IDLE, CLEAR, GATE, SETTLE, CAPTURE, HOLD.
- IDLE: `cnt_enable`=0, `cnt_reset`=1; the counter keeps its last value. Transition to CLEAR when `start`=1 or `continuous`=1.
- Entry to CLEAR latches `range` into an internal register. Later `range` changes do not affect the cycle in progress.
- CLEAR: `cnt_reset`=0 for exactly CLR_CYCLES cycles, then GATE.
- GATE: `cnt_reset`=1 and `cnt_enable`=1 for exactly GATEn cycles, where n is the latched range. Then SETTLE.
- SETTLE: `cnt_enable`=0 for SETTLE_CYCLES cycles so `count_in` becomes static. Then CAPTURE. `count_in` is sampled only here, so no multi-bit synchroniser is needed.
- CAPTURE: 1 cycle. On the exit edge, `result`←`count_in`, `result_range`←latched range, and `result_valid`=1 for the following cycle. Then HOLD.
- HOLD: HOLD_CYCLES cycles. At the end, go to CLEAR if `continuous`=1, otherwise IDLE.
- `start` while `busy`=1 is ignored and is not queued.
- Dropping `continuous` mid-cycle does not abort the cycle. The current measurement completes and returns to IDLE after HOLD.
- A counter wrap above 9999 is not detected. The range choice is the user's responsibility.
- `result` is held unchanged outside CAPTURE.

## Timing
- Reset values: state IDLE, `cnt_enable`=0, `cnt_reset`=0 (asserting `reset` also clears the counter), `result`=0, `result_range`=0, `result_valid`=0, `busy`=0. `cnt_reset` returns to 1 on the first clk edge after reset release.
- Reset mid-operation aborts immediately. No partial result is written.
- Latency from `start` sampled high to `result_valid`: CLR_CYCLES + GATEn + SETTLE_CYCLES + 2 cycles.
- `busy` rises on the edge that enters CLEAR.
- The timer is a down-counter, loaded with N−1 on state entry. The state exits on the edge where the timer reads 0, so every phase lasts exactly N cycles.
- In continuous mode, the period is CLR_CYCLES + GATEn + SETTLE_CYCLES + 1 + HOLD_CYCLES cycles. There is no IDLE cycle between measurements.

## Structure
- Package `freq_meter_pkg` holds:
  - the state enum;
  - the range encoding constants RANGE_1S..RANGE_1MS;
  - the timer width default.
- Sub-module `gate_timer` is a TW-bit loadable down-counter with `load`, `load_val` and `done` (count==0). A single instance is shared by all timed states.
- The FSM and output registers live in `freq_meter_ctrl`. All outputs are registered.

## Test plan
Use small parameters: GATE0..3 = 100/50/20/10, CLR=2, SETTLE=2, HOLD=5.
- Single shot: `start` pulse with `range`=2 → `cnt_reset` low 2 cycles, `cnt_enable` high exactly 20 cycles, `result_valid` 26 cycles after `start`. With `count_in` model = 16'h0437 → `result`=16'h0437, `result_range`=2.
- Continuous: hold `continuous` high with `range`=3 → `result_valid` pulses every 20 cycles. Drop `continuous` mid-GATE → the cycle completes and IDLE follows HOLD.
- Range change: `range` 0→1 during GATE → gate stays 100 cycles and `result_range`=0.
- Start while busy: `start` pulse during SETTLE → no extra measurement and no second `result_valid`.
- Reset mid-GATE: assert `reset` → `cnt_enable`=0 and `cnt_reset`=0 asynchronously, `result` keeps its reset value 0, `busy`=0.
- Boundary: `count_in`=16'h9999 captured → `result`=16'h9999 unchanged. Check that `cnt_enable` is 0 throughout CLEAR, SETTLE, CAPTURE and HOLD.

Source files
------------

// File: rtl/freq_meter_pkg.sv
// Shared types and constants for the frequency meter measurement sequencer.
// Range codes select the gate length; the timer width default sizes the phase timer.
package freq_meter_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StGate,
        StSettle,
        StCapture,
        StHold
    } state_e;

    localparam logic [1:0] RANGE_1S    = 2'd0;
    localparam logic [1:0] RANGE_100MS = 2'd1;
    localparam logic [1:0] RANGE_10MS  = 2'd2;
    localparam logic [1:0] RANGE_1MS   = 2'd3;

    localparam int unsigned TW_DEFAULT = 24;

endpackage

// File: rtl/gate_timer.sv
// Loadable down-counter shared by every timed phase of the sequencer.
// Holds at zero once expired; done reflects the current count being zero.
module gate_timer
    import freq_meter_pkg::*;
#(
    parameter int unsigned TW = TW_DEFAULT
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic [TW-1:0] load_val,
    output logic          done
);

    logic [TW-1:0] count_q;
    logic [TW-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (count_q != '0) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign done = (count_q == '0);

endmodule

// File: rtl/freq_meter_ctrl.sv
// Measurement sequencer: clears the BCD counter, gates it for a timed window,
// lets it settle and captures the result. All outputs are registered.
module freq_meter_ctrl
    import freq_meter_pkg::*;
#(
    parameter int unsigned GATE0         = 1_000_000,
    parameter int unsigned GATE1         = 100_000,
    parameter int unsigned GATE2         = 10_000,
    parameter int unsigned GATE3         = 1_000,
    parameter int unsigned CLR_CYCLES    = 2,
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned HOLD_CYCLES   = 500_000,
    parameter int unsigned TW            = TW_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        continuous,
    input  logic [1:0]  range,
    input  logic [15:0] count_in,
    output logic        cnt_enable,
    output logic        cnt_reset,
    output logic [15:0] result,
    output logic [1:0]  result_range,
    output logic        result_valid,
    output logic        busy
);

    state_e        state_q, state_d;
    logic [1:0]    range_q;
    logic [TW-1:0] gate_len;
    logic          tmr_load;
    logic [TW-1:0] tmr_val;
    logic          tmr_done;

    logic          cnt_enable_q, cnt_reset_q, result_valid_q, busy_q;
    logic [15:0]   result_q;
    logic [1:0]    result_range_q;

    gate_timer #(
        .TW(TW)
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .load    (tmr_load),
        .load_val(tmr_val),
        .done    (tmr_done)
    );

    always_comb begin
        unique case (range_q)
            RANGE_1S:    gate_len = TW'(GATE0 - 1);
            RANGE_100MS: gate_len = TW'(GATE1 - 1);
            RANGE_10MS:  gate_len = TW'(GATE2 - 1);
            RANGE_1MS:   gate_len = TW'(GATE3 - 1);
        endcase
    end

    // Timer is loaded with N-1 on the edge that enters each timed phase.
    always_comb begin
        state_d  = state_q;
        tmr_load = 1'b0;
        tmr_val  = '0;
        unique case (state_q)
            StIdle: begin
                if (start || continuous) begin
                    state_d  = StClear;
                    tmr_load = 1'b1;
                    tmr_val  = TW'(CLR_CYCLES - 1);
                end
            end
            StClear: begin
                if (tmr_done) begin
                    state_d  = StGate;
                    tmr_load = 1'b1;
                    tmr_val  = gate_len;
                end
            end
            StGate: begin
                if (tmr_done) begin
                    state_d  = StSettle;
                    tmr_load = 1'b1;
                    tmr_val  = TW'(SETTLE_CYCLES - 1);
                end
            end
            StSettle: begin
                if (tmr_done) begin
                    state_d = StCapture;
                end
            end
            StCapture: begin
                state_d  = StHold;
                tmr_load = 1'b1;
                tmr_val  = TW'(HOLD_CYCLES - 1);
            end
            StHold: begin
                if (tmr_done) begin
                    if (continuous) begin
                        state_d  = StClear;
                        tmr_load = 1'b1;
                        tmr_val  = TW'(CLR_CYCLES - 1);
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= StIdle;
            range_q        <= RANGE_1S;
            cnt_enable_q   <= 1'b0;
            cnt_reset_q    <= 1'b0;
            busy_q         <= 1'b0;
            result_q       <= '0;
            result_range_q <= RANGE_1S;
            result_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_enable_q   <= (state_d == StGate);
            cnt_reset_q    <= (state_d != StClear);
            busy_q         <= (state_d != StIdle);
            result_valid_q <= (state_q == StCapture);
            if (state_q == StCapture) begin
                result_q       <= count_in;
                result_range_q <= range_q;
            end
            if (state_d == StClear && state_q != StClear) begin
                range_q <= range;
            end
        end
    end

    assign cnt_enable   = cnt_enable_q;
    assign cnt_reset    = cnt_reset_q;
    assign result       = result_q;
    assign result_range = result_range_q;
    assign result_valid = result_valid_q;
    assign busy         = busy_q;

endmodule
